// File: rtl/cache_pkg.sv
// Shared types and derived widths for the direct-mapped instruction cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REFILL    = 2'd1,
      FILL_DONE = 2'd2
   } cache_state_t;

   localparam logic [31:0] NOP = 32'h0;

   function automatic int calc_off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int calc_idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag is whatever remains above index, offset and the two byte bits.
   function automatic int calc_tag_w(input int addr_w, input int lines, input int words_per_line);
      return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
   endfunction

endpackage

// File: rtl/cache_refill_fsm.sv
// Miss handling for the instruction cache: line refill over a word-serial
// req/ack memory port, pending-invalidate bookkeeping and the miss counter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | lookups active; a miss latches the line base and starts refill
// REFILL    | MEM_REQ high, one word written per MEM_ACK until line full
// FILL_DONE | one bubble cycle after the last word, then back to IDLE
module cache_refill_fsm
   import cache_pkg::*;
#(
   parameter int   WORDS_PER_LINE = 4,
   parameter int   ADDR_W         = 32,
   parameter int   CNT_W          = 16,
   localparam int  OFF_W          = calc_off_w(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookup_miss,
   input  logic [ADDR_W-1:0] line_base,
   input  logic              invalidate,
   input  logic              mem_ack,
   output cache_state_t      state,
   output logic [OFF_W-1:0]  word_cnt,
   output logic [ADDR_W-1:0] miss_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [CNT_W-1:0]  miss_count,
   output logic              fill_we,
   output logic              fill_last,
   output logic              flush_valid
);

   logic inv_pending;

   assign fill_we   = (state == REFILL) && mem_ack;
   assign fill_last = fill_we && (word_cnt == '1);

   // A flush outside REFILL is immediate; inside REFILL it waits for the
   // final word and then beats the valid-set of that same word.
   assign flush_valid = (invalidate && (state != REFILL)) ||
                        (fill_last && (inv_pending || invalidate));

   // Refill sequencing with registered memory request and address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         word_cnt    <= '0;
         miss_addr   <= '0;
         inv_pending <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         miss_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (lookup_miss) begin
                  miss_addr <= line_base;
                  mem_addr  <= line_base;
                  word_cnt  <= '0;
                  mem_req   <= 1'b1;
                  if (miss_count != '1)
                     miss_count <= miss_count + 1'b1;
                  state     <= REFILL;
               end
            end
            REFILL: begin
               if (invalidate)
                  inv_pending <= 1'b1;
               if (mem_ack) begin
                  word_cnt <= word_cnt + 1'b1;
                  mem_addr <= mem_addr + ADDR_W'(4);
                  if (word_cnt == '1) begin
                     mem_req     <= 1'b0;
                     inv_pending <= 1'b0;
                     state       <= FILL_DONE;
                  end
               end
            end
            FILL_DONE: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with zero-latency lookup.
// Holds tag/valid/data arrays; refill control lives in cache_refill_fsm.
module instruction_cache
   import cache_pkg::*;
#(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] PC,
   input  logic              INVALIDATE,
   output logic [31:0]       INSTRUCTION,
   output logic              HIT,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_ACK,
   input  logic [31:0]       MEM_DATA,
   output logic [CNT_W-1:0]  MISS_COUNT
);

   localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
   localparam int IDX_W = calc_idx_w(LINES);
   localparam int TAG_W = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE);
   localparam int LO_W  = OFF_W + 2;

   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [LINES-1:0] valid;
   logic [31:0]      data_arr [LINES*WORDS_PER_LINE];

   cache_state_t      state;
   logic [OFF_W-1:0]  word_cnt;
   logic [ADDR_W-1:0] miss_addr;
   logic              fill_we;
   logic              fill_last;
   logic              flush_valid;

   logic [OFF_W-1:0]  pc_off;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic [IDX_W-1:0]  miss_idx;
   logic [TAG_W-1:0]  miss_tag;
   logic [ADDR_W-1:0] line_base;
   logic              hit_c;

   // Byte bits of PC and the always-zero low bits of miss_addr carry no information.
   logic unused_low_bits;
   assign unused_low_bits = ^{PC[1:0], miss_addr[LO_W-1:0]};

   assign pc_off    = PC[LO_W-1:2];
   assign pc_idx    = PC[IDX_W+LO_W-1:LO_W];
   assign pc_tag    = PC[ADDR_W-1:IDX_W+LO_W];
   assign line_base = {PC[ADDR_W-1:LO_W], {LO_W{1'b0}}};
   assign miss_idx  = miss_addr[IDX_W+LO_W-1:LO_W];
   assign miss_tag  = miss_addr[ADDR_W-1:IDX_W+LO_W];

   assign hit_c       = (state == IDLE) && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
   assign HIT         = hit_c;
   assign INSTRUCTION = hit_c ? data_arr[{pc_idx, pc_off}] : NOP;

   cache_refill_fsm #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .ADDR_W         (ADDR_W),
      .CNT_W          (CNT_W)
   ) u_refill (
      .clk         (clk),
      .rst         (rst),
      .lookup_miss (!hit_c),
      .line_base   (line_base),
      .invalidate  (INVALIDATE),
      .mem_ack     (MEM_ACK),
      .state       (state),
      .word_cnt    (word_cnt),
      .miss_addr   (miss_addr),
      .mem_req     (MEM_REQ),
      .mem_addr    (MEM_ADDR),
      .miss_count  (MISS_COUNT),
      .fill_we     (fill_we),
      .fill_last   (fill_last),
      .flush_valid (flush_valid)
   );

   // Valid bits: flush wins over the final refill word's set.
   always_ff @(posedge clk) begin
      if (rst)
         valid <= '0;
      else if (flush_valid)
         valid <= '0;
      else if (fill_last)
         valid[miss_idx] <= 1'b1;
   end

   // Tag written with the last word; stale tags are harmless while valid is low.
   always_ff @(posedge clk) begin
      if (fill_last)
         tag_arr[miss_idx] <= miss_tag;
   end

   // Data words land as they are acknowledged.
   always_ff @(posedge clk) begin
      if (fill_we)
         data_arr[{miss_idx, word_cnt}] <= MEM_DATA;
   end

endmodule
